qm_fetch_queue: RTL and testbench
=================================

# qm_fetch_queue

Parametrised fetch stage with a decoupling instruction queue: generates the fetch PC, drives the ICache handshake, and buffers up to DEPTH fetched instructions with their PCs in front of decode. Successor to the fixed single-register fetch/decode boundary. Adds miss holding, branch/jump redirect with flush, and valid/ready backpressure toward decode. Sits between `qm_icache` and the decode stage in the pipeline top.

## Interface
- ADDR_W, 32, PC / ICache address width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- sys_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- icache_address  out  ADDR_W  fetch address
- icache_enable  out  1  fetch request this cycle
- icache_hit  in  1  icache_data valid for icache_address
- icache_should_stall  in  1  cache busy; the hit is ignored
- icache_data  in  DATA_W  instruction word
- redirect_valid  in  1  branch/jump/exception redirect
- redirect_pc  in  ADDR_W  redirect target
- do_valid  out  1  queue head valid
- do_ready  in  1  decode accepts head
- do_IR  out  DATA_W  head instruction
- do_PC  out  ADDR_W  head PC
- do_NextPC  out  ADDR_W  head PC + 4
- level  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State machine with states IDLE, RUN and MISS.
  - IDLE: lasts only the first cycle after reset. icache_enable=0. Moves to RUN.
  - RUN: icache_enable=1 when space is available. Space is available when level<DEPTH, or when do_valid&&do_ready (pop).
  - RUN → MISS: when enable is high and the fetch does not complete (!icache_hit || icache_should_stall).
  - MISS: icache_address and icache_enable are held. Moves to RUN on the completing cycle.
- Fetch completes when icache_enable && icache_hit && !icache_should_stall.
  - On completion: push {PC, icache_data} and increment PC by 4, with modulo 2^ADDR_W wrap.
- Pop: when do_valid && do_ready, the head advances.
  - Push and pop in the same cycle leave level unchanged. This is legal when full.
- Redirect has priority over everything, in every state:
  - Queue is flushed and level becomes 0.
  - No push and no pop that cycle.
  - PC ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Next state is RUN.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- full = (level==DEPTH); empty = (level==0).
- do_valid = !empty. do_IR, do_PC and do_NextPC are taken from the head entry. Their values are don't-care when do_valid=0.
- icache_address = PC at all times.

## Timing
- Reset values:
  - PC = RESET_PC, state IDLE, level 0.
  - do_valid 0, icache_enable 0, icache_address RESET_PC.
  - do_IR, do_PC, do_NextPC are 0.
- Latency: a fetch completing at cycle t makes the entry visible (do_valid=1 if the queue was empty) at t+1.
- Throughput: one instruction per cycle while hits continue and decode is ready.
- Redirect at t:
  - At t+1: level=0 and icache_address=redirect target.
  - First redirected instruction is valid at t+2 if it hits.
- do_ready has a combinational path to icache_enable through the pop term. No other input reaches an output combinationally.
- Reset asserted mid-miss or mid-queue: all state returns to the reset values immediately, and the queue contents are discarded.

## Configuration
- QM_FETCH_STATS_EN defined: adds output `stall_cycles` (out, 32 bits).
  - Increments every cycle where icache_enable=1 and the fetch does not complete.
  - Saturates at 0xFFFF_FFFF.
  - Reset value 0.
  - Not cleared by redirect.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `qm_pkg`:
  - state enum {IDLE, RUN, MISS}
  - RESET_PC default constant
  - instruction-word width constant
- One natural sub-module, `qm_sync_fifo`: DEPTH×(ADDR_W+DATA_W) storage with pointers, level, and a synchronous flush input.
- The fetch FSM/PC logic stays in `qm_fetch_queue`.

## Test plan
1. Reset, all hits, do_ready=1:
   - icache_address goes BFC0_0000, BFC0_0004, BFC0_0008, …
   - do_PC matches each fetched address one cycle later.
   - level stays ≤1.
2. do_ready=0, all hits:
   - level climbs to 4.
   - icache_enable drops to 0 while full.
   - PC holds at BFC0_0010.
   - Raising do_ready pops BFC0_0000 first, and fetch resumes the same cycle.
3. Miss on BFC0_0008 for 3 cycles (hit=0), then a hit with should_stall=1 for 1 cycle:
   - Address is held for 4 cycles.
   - Exactly one entry is pushed, with IR from the completing cycle.
4. Queue at level 3, redirect_valid with redirect_pc=8000_0103:
   - Next cycle level=0 and icache_address=8000_0100.
   - The next do_PC is 8000_0100.
5. Full queue with do_ready=1 and a hit in the same cycle: level stays 4, and the order is preserved.
6. PC=FFFF_FFFC hits: the next icache_address is 0000_0000. With QM_FETCH_STATS_EN, stall_cycles equals the count of miss cycles.

Source files
------------

// File: rtl/qm_pkg.sv
// qm_pkg
//   Shared definitions for the qm fetch front end.
//   - fetch_state_t : fetch FSM states (IDLE, RUN, MISS)
//   - QM_RESET_PC   : default first fetch address after reset
//   - QM_INSN_W     : instruction word width
//   - QM_INSN_BYTES : PC increment per fetched instruction
package qm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } fetch_state_t;

  localparam logic [31:0] QM_RESET_PC   = 32'hBFC0_0000;
  localparam int          QM_INSN_W     = 32;
  localparam logic [31:0] QM_INSN_BYTES = 32'd4;

endpackage

// File: rtl/qm_sync_fifo.sv
// qm_sync_fifo
//   Synchronous FIFO of DEPTH entries, WIDTH bits each, with a synchronous
//   flush. Pointers are log2(DEPTH) bits and wrap naturally (DEPTH is a
//   power of two); the occupancy is tracked in a separate level counter so
//   full and empty are unambiguous.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : empties the FIFO; overrides push and pop
//   push, wdata   : write request and data (ignored when full without pop)
//   pop           : advance the head (ignored when empty)
//   rdata         : head entry
//   level         : occupied entries
//   empty, full   : occupancy flags
module qm_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // A push into a full FIFO is only accepted when a pop frees the slot in
  // the same cycle; flush suppresses both operations.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through rdata while
  // the level says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/qm_fetch_queue.sv
// qm_fetch_queue
//   Fetch stage with a decoupling instruction queue. Generates the fetch PC,
//   drives the ICache request, holds the request across misses, redirects
//   and flushes on branch/jump/exception, and buffers up to DEPTH fetched
//   {PC, instruction} pairs in front of decode with valid/ready handshake.
// Ports:
//   sys_clk, reset          : clock, asynchronous active-high reset
//   icache_address/_enable  : fetch request (address is the PC at all times)
//   icache_hit/_should_stall/_data : ICache response
//   redirect_valid/_pc      : redirect request, highest priority
//   do_valid/do_ready       : decode handshake for the queue head
//   do_IR/do_PC/do_NextPC   : head instruction, its PC and PC+4 (0 when empty)
//   level                   : occupied queue entries
//   stall_cycles            : only with QM_FETCH_STATS_EN defined; saturating
//                             count of requested-but-not-completed cycles
module qm_fetch_queue
  import qm_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = QM_INSN_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(QM_RESET_PC)
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          icache_address,
  output logic                       icache_enable,
  input  logic                       icache_hit,
  input  logic                       icache_should_stall,
  input  logic [DATA_W-1:0]          icache_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       do_valid,
  input  logic                       do_ready,
  output logic [DATA_W-1:0]          do_IR,
  output logic [ADDR_W-1:0]          do_PC,
  output logic [ADDR_W-1:0]          do_NextPC,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef QM_FETCH_STATS_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic [ADDR_W-1:0]    pc;
  logic                 empty;
  logic                 full;
  logic                 pop_req;
  logic                 space;
  logic                 resp_ok;
  logic                 complete;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   head;
  logic [ADDR_W-1:0]    head_pc;
  logic                 unused_redirect_bits;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign do_valid = !empty;
  assign pop_req  = do_valid && do_ready;
  // A pop in this cycle frees a slot for the word being fetched, which is
  // the one combinational path from do_ready to icache_enable.
  assign space    = !full || pop_req;
  assign resp_ok  = icache_hit && !icache_should_stall;
  assign complete = icache_enable && resp_ok;
  assign push     = complete && !redirect_valid;
  assign pop      = pop_req && !redirect_valid;

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and request enable. MISS keeps the request up until the
  // cache answers; it can only be entered with a free slot, and pops during
  // the miss only add room, so no space check is needed there.
  always_comb begin
    state_next    = state;
    icache_enable = 1'b0;
    case (state)
      IDLE: begin
        state_next = RUN;
      end
      RUN: begin
        icache_enable = space;
        if (space && !resp_ok) state_next = MISS;
      end
      MISS: begin
        icache_enable = 1'b1;
        if (resp_ok) state_next = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redirect_valid) state_next = RUN;
  end

  // Fetch PC: redirect wins, otherwise advance on each completed fetch.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (complete)       pc <= pc + ADDR_W'(QM_INSN_BYTES);
  end

  assign icache_address = pc;

  qm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (sys_clk),
    .rst   (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({pc, icache_data}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // Head fields are forced to zero while empty so the outputs are clean
  // after reset without having to reset the storage array.
  assign head_pc   = head[ENTRY_W-1:DATA_W];
  assign do_IR     = do_valid ? head[DATA_W-1:0] : '0;
  assign do_PC     = do_valid ? head_pc : '0;
  assign do_NextPC = do_valid ? head_pc + ADDR_W'(QM_INSN_BYTES) : '0;

`ifdef QM_FETCH_STATS_EN
  // Saturating stall counter; survives redirects, cleared only by reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (icache_enable && !complete && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qm_fetch_queue.sv
// tb_qm_fetch_queue
//   Directed testbench for qm_fetch_queue. The ICache is modelled as a word
//   store whose data is address ^ MAGIC unless an override word is selected.
//   Define QM_FETCH_STATS_EN to also check stall_cycles.
module tb_qm_fetch_queue;

  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;

  logic        sys_clk;
  logic        reset;
  logic [31:0] icache_address;
  logic        icache_enable;
  logic        icache_hit;
  logic        icache_should_stall;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        do_valid;
  logic        do_ready;
  logic [31:0] do_IR;
  logic [31:0] do_PC;
  logic [31:0] do_NextPC;
  logic [2:0]  level;
`ifdef QM_FETCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  logic        data_override_en;
  logic [31:0] data_override;
  int          tests_run;
  int          failures;

  qm_fetch_queue dut (
    .sys_clk             (sys_clk),
    .reset               (reset),
    .icache_address      (icache_address),
    .icache_enable       (icache_enable),
    .icache_hit          (icache_hit),
    .icache_should_stall (icache_should_stall),
    .icache_data         (icache_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .do_valid            (do_valid),
    .do_ready            (do_ready),
    .do_IR               (do_IR),
    .do_PC               (do_PC),
    .do_NextPC           (do_NextPC),
    .level               (level)
`ifdef QM_FETCH_STATS_EN
    ,
    .stall_cycles        (stall_cycles)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ICache data model.
  always_comb begin
    icache_data = icache_address ^ MAGIC;
    if (data_override_en) icache_data = data_override;
  end

  // Advance one clock and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Holds reset for two edges with the given do_ready, then releases it just
  // after an edge; the DUT is in IDLE until the next rising edge.
  task automatic apply_reset(input logic ready);
    reset               = 1'b1;
    icache_hit          = 1'b1;
    icache_should_stall = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    do_ready            = ready;
    data_override_en    = 1'b0;
    data_override       = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    reset = 1'b1;
    #1;
    tests_run++;
    if (icache_address !== 32'hBFC0_0000) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=%h", icache_address, 32'hBFC0_0000); end
    tests_run++;
    if (icache_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable got=%b exp=0", icache_enable); end
    tests_run++;
    if (do_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("[TB] FAIL reset_queue valid=%b level=%0d exp valid=0 level=0", do_valid, level); end
    tests_run++;
    if (do_IR !== 32'h0 || do_PC !== 32'h0 || do_NextPC !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_head IR=%h PC=%h NextPC=%h exp all 0", do_IR, do_PC, do_NextPC);
    end
`ifdef QM_FETCH_STATS_EN
    tests_run++;
    if (stall_cycles !== 32'd0) begin failures++; $display("[TB] FAIL reset_stats got=%0d exp=0", stall_cycles); end
`endif
    reset = 1'b0;
    #1;
    tests_run++;
    if (icache_enable !== 1'b0) begin failures++; $display("[TB] FAIL idle_enable got=%b exp=0", icache_enable); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    apply_reset(1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_addr = 32'hBFC0_0000 + 32'(4 * i);
      tests_run++;
      if (icache_address !== exp_addr || icache_enable !== 1'b1) begin
        failures++; $display("[TB] FAIL stream_addr[%0d] got=%h en=%b exp=%h en=1", i, icache_address, icache_enable, exp_addr);
      end
      if (i > 0) begin
        tests_run++;
        if (do_valid !== 1'b1 || do_PC !== exp_addr - 32'd4 || do_IR !== ((exp_addr - 32'd4) ^ MAGIC) ||
            do_NextPC !== exp_addr || level !== 3'd1) begin
          failures++;
          $display("[TB] FAIL stream_head[%0d] valid=%b PC=%h IR=%h Next=%h level=%0d exp PC=%h level=1",
                   i, do_valid, do_PC, do_IR, do_NextPC, level, exp_addr - 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (level !== 3'd4 || icache_enable !== 1'b0 || icache_address !== 32'hBFC0_0010) begin
        failures++; $display("[TB] FAIL full_hold[%0d] level=%0d en=%b addr=%h exp 4 0 bfc00010", i, level, icache_enable, icache_address);
      end
      tick();
    end
    do_ready = 1'b1;
    #1;
    tests_run++;
    if (icache_enable !== 1'b1 || do_PC !== 32'hBFC0_0000) begin
      failures++; $display("[TB] FAIL full_release en=%b PC=%h exp en=1 PC=bfc00000", icache_enable, do_PC);
    end
  endtask

  // Continues from a full queue with do_ready=1 and hits.
  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if (level !== 3'd4 || do_PC !== 32'hBFC0_0000 + 32'(4 * i) || icache_address !== 32'hBFC0_0010 + 32'(4 * i)) begin
        failures++;
        $display("[TB] FAIL full_pushpop[%0d] level=%0d PC=%h addr=%h exp level=4 PC=%h addr=%h",
                 i, level, do_PC, icache_address, 32'hBFC0_0000 + 32'(4 * i), 32'hBFC0_0010 + 32'(4 * i));
      end
    end
  endtask

  // Asynchronous reset with a full queue.
  task automatic test_reset_midstream();
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (level !== 3'd0 || do_valid !== 1'b0 || icache_address !== 32'hBFC0_0000 || icache_enable !== 1'b0 || do_PC !== 32'h0) begin
      failures++; $display("[TB] FAIL async_reset level=%0d valid=%b addr=%h en=%b PC=%h", level, do_valid, icache_address, icache_enable, do_PC);
    end
  endtask

  task automatic test_miss();
    apply_reset(1'b1);
    tick();
    tick();
    tick();
    icache_hit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        icache_hit = 1'b1; icache_should_stall = 1'b1;
        data_override_en = 1'b1; data_override = 32'h1111_1111;
      end
      if (k == 4) begin
        icache_should_stall = 1'b0; data_override = 32'hDEAD_BEEF;
      end
      #1;
      tests_run++;
      if (icache_address !== 32'hBFC0_0008 || icache_enable !== 1'b1) begin
        failures++; $display("[TB] FAIL miss_hold[%0d] addr=%h en=%b exp bfc00008 1", k, icache_address, icache_enable);
      end
      tick();
    end
    tests_run++;
    if (do_valid !== 1'b1 || do_PC !== 32'hBFC0_0008 || do_IR !== 32'hDEAD_BEEF || level !== 3'd1 || icache_address !== 32'hBFC0_000C) begin
      failures++; $display("[TB] FAIL miss_push valid=%b PC=%h IR=%h level=%0d addr=%h exp 1 bfc00008 deadbeef 1 bfc0000c",
                           do_valid, do_PC, do_IR, level, icache_address);
    end
`ifdef QM_FETCH_STATS_EN
    tests_run++;
    if (stall_cycles !== 32'd4) begin failures++; $display("[TB] FAIL miss_stats got=%0d exp=4", stall_cycles); end
`endif
    do_ready = 1'b0; icache_hit = 1'b0; data_override_en = 1'b0;
    tick();
    tests_run++;
    if (level !== 3'd1) begin failures++; $display("[TB] FAIL miss_single level=%0d exp=1", level); end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    tick();
    tick(); tick(); tick();
    tests_run++;
    if (level !== 3'd3 || icache_address !== 32'hBFC0_000C) begin
      failures++; $display("[TB] FAIL redir_pre level=%0d addr=%h exp 3 bfc0000c", level, icache_address);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (level !== 3'd0 || do_valid !== 1'b0 || icache_address !== 32'h8000_0100) begin
      failures++; $display("[TB] FAIL redir_flush level=%0d valid=%b addr=%h exp 0 0 80000100", level, do_valid, icache_address);
    end
    tick();
    tests_run++;
    if (do_valid !== 1'b1 || do_PC !== 32'h8000_0100 || do_NextPC !== 32'h8000_0104 || do_IR !== (32'h8000_0100 ^ MAGIC)) begin
      failures++; $display("[TB] FAIL redir_head valid=%b PC=%h Next=%h IR=%h exp PC=80000100", do_valid, do_PC, do_NextPC, do_IR);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (icache_address !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pre addr=%h exp fffffffc", icache_address); end
    tick();
    tests_run++;
    if (icache_address !== 32'h0000_0000 || do_PC !== 32'hFFFF_FFFC || do_NextPC !== 32'h0000_0000) begin
      failures++; $display("[TB] FAIL wrap addr=%h PC=%h Next=%h exp 00000000 fffffffc 00000000", icache_address, do_PC, do_NextPC);
    end
    icache_hit = 1'b0;
    tick(); tick();
`ifdef QM_FETCH_STATS_EN
    tests_run++;
    if (stall_cycles !== 32'd2) begin failures++; $display("[TB] FAIL wrap_stats got=%0d exp=2", stall_cycles); end
`endif
    icache_hit = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (icache_address !== 32'h0000_0040 || level !== 3'd0) begin
      failures++; $display("[TB] FAIL miss_redirect addr=%h level=%0d exp 00000040 0", icache_address, level);
    end
`ifdef QM_FETCH_STATS_EN
    tests_run++;
    if (stall_cycles !== 32'd2) begin failures++; $display("[TB] FAIL stats_keep got=%0d exp=2", stall_cycles); end
`endif
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    reset     = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_reset_midstream();
    test_miss();
    test_redirect();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
